// File: rtl/pipe_mem_stage.sv
// ---------------------------------------------------------------------------
// pipe_mem_stage
//
// MEM-stage data-memory access unit between the EX/MEM and MEM/WB registers.
// Accepts one load/store from the EX/MEM register, runs it on a req/ack
// data-memory bus, and returns the aligned, extended load result. The
// pipeline is stalled until the access completes.
//
// Parameters
//   TIMEOUT_CYCLES  REQ cycles without dmem_ack before the access is
//                   abandoned with Mbus_err (1..255)
//
// Optional feature (compile-time macro ALIGN_CHECK_EN)
//   Adds output Mmisalign. A misaligned halfword/word access issues no bus
//   request, takes one stall cycle and pulses Mmisalign during DONE.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   Mvalid        MEM-stage instruction valid
//   Mmem_op       0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 sb, 7 sh, 8 sw
//   Malu          effective byte address
//   Mstore_data   store source register value
//   dmem_*        data-memory bus (req/we/addr/be/wdata out, ack/rdata in)
//   Mdmem_rdata   extended load result, held until the next load completes
//   Mbus_err      last access timed out, held until the next access completes
//   Mmisalign     (ALIGN_CHECK_EN only) misaligned access, high in DONE
//   mem_stall     freeze the front of the pipe; MEM/WB loads a bubble
// ---------------------------------------------------------------------------
module pipe_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Mvalid,
  input  logic [3:0]  Mmem_op,
  input  logic [31:0] Malu,
  input  logic [31:0] Mstore_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] Mdmem_rdata,
  output logic        Mbus_err,
`ifdef ALIGN_CHECK_EN
  output logic        Mmisalign,
`endif
  output logic        mem_stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        mem_op;
  logic        misalign_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic        we_in;
  logic        op_is_load;
  logic [31:0] load_val;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Gating with rst_n keeps mem_stall low while reset is held even if the
  // EX/MEM register still presents a memory instruction.
  assign mem_op = rst_n && Mvalid && (Mmem_op >= OP_LB) && (Mmem_op <= OP_SW);

  // Store/load lane selection for the incoming instruction.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    be_in       = 4'b0000;
    wdata_in    = Mstore_data;
    we_in       = 1'b0;
    misalign_in = 1'b0;
    case (Mmem_op)
      OP_LB, OP_LBU, OP_SB: begin
        be_in    = 4'b0001 << Malu[1:0];
        wdata_in = {4{Mstore_data[7:0]}};
        we_in    = (Mmem_op == OP_SB);
      end
      OP_LH, OP_LHU, OP_SH: begin
        be_in       = Malu[1] ? 4'b1100 : 4'b0011;
        wdata_in    = {2{Mstore_data[15:0]}};
        we_in       = (Mmem_op == OP_SH);
        misalign_in = Malu[0];
      end
      OP_LW, OP_SW: begin
        be_in       = 4'b1111;
        wdata_in    = Mstore_data;
        we_in       = (Mmem_op == OP_SW);
        misalign_in = (Malu[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  // Load extraction works on the latched op and address.
  assign op_is_load = (op_q >= OP_LB) && (op_q <= OP_LW);
  assign byte_lane  = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_lane  = dmem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = dmem_rdata;
    case (op_q)
      OP_LB:   load_val = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_val = {24'd0, byte_lane};
      OP_LH:   load_val = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_val = {16'd0, half_lane};
      default: load_val = dmem_rdata;
    endcase
  end

  // Next state and stall.
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_stall = mem_op;
        if (mem_op) begin
`ifdef ALIGN_CHECK_EN
          state_d = misalign_in ? S_DONE : S_REQ;
`else
          state_d = S_REQ;
`endif
        end
      end
      S_REQ: begin
        mem_stall = 1'b1;
        if (dmem_ack || (cnt_q == CNT_LAST)) state_d = S_DONE;
      end
      // The instruction leaves at the end of DONE; whatever is presented
      // here is that same instruction and must not be accepted again.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          mis_q <= 1'b0;
    else if (state_q == S_IDLE && mem_op && misalign_in) mis_q <= 1'b1;
    else if (state_q == S_DONE)                          mis_q <= 1'b0;
  end

  assign Mmisalign = mis_q;
`else
  // Low address bits beyond the access width are simply not used.
  logic unused_misalign;
  assign unused_misalign = misalign_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      we_q    <= 1'b0;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            op_q    <= Mmem_op;
            addr_q  <= Malu;
            wdata_q <= wdata_in;
            be_q    <= be_in;
            we_q    <= we_in;
            cnt_q   <= 8'd0;
          end
        end
        S_REQ: begin
          if (dmem_ack) begin
            err_q <= 1'b0;
            if (op_is_load) rdata_q <= load_val;
          end else if (cnt_q == CNT_LAST) begin
            err_q <= 1'b1;
            if (op_is_load) rdata_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req    = (state_q == S_REQ);
  assign dmem_we     = we_q;
  assign dmem_addr   = {addr_q[31:2], 2'b00};
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;
  assign Mdmem_rdata = rdata_q;
  assign Mbus_err    = err_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
module tb_pipe_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Mvalid = 1'b0;
  logic [3:0]  Mmem_op = 4'd0;
  logic [31:0] Malu = 32'd0;
  logic [31:0] Mstore_data = 32'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic [31:0] Mdmem_rdata;
  logic        Mbus_err;
  logic        mem_stall;
`ifdef ALIGN_CHECK_EN
  logic        Mmisalign;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Mvalid      (Mvalid),
    .Mmem_op     (Mmem_op),
    .Malu        (Malu),
    .Mstore_data (Mstore_data),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .Mdmem_rdata (Mdmem_rdata),
    .Mbus_err    (Mbus_err),
`ifdef ALIGN_CHECK_EN
    .Mmisalign   (Mmisalign),
`endif
    .mem_stall   (mem_stall)
  );

  // Bus-side driver: presents one instruction and acts as memory, acking
  // after 'waits' REQ cycles (negative = never). Returns when mem_stall
  // drops (DONE cycle). Records what the bus showed during REQ.
  logic [3:0]  obs_be;
  logic [31:0] obs_wd, obs_addr;
  logic        obs_we, obs_mis;
  int          obs_stalls, obs_reqs;
  bit          obs_done;

  task automatic do_access(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] sd, input int waits,
                           input logic [31:0] rd, input bit keep);
    int wcnt;
    wcnt = 0;
    obs_stalls = 0; obs_reqs = 0; obs_done = 0; obs_mis = 0;
    obs_be = 'x; obs_wd = 'x; obs_addr = 'x; obs_we = 'x;
    @(negedge clk);
    Mvalid = 1'b1; Mmem_op = op; Malu = a; Mstore_data = sd;
    for (int cyc = 0; cyc < 300; cyc++) begin
      dmem_ack = 1'b0;
      if (dmem_req) begin
        obs_reqs++;
        obs_be = dmem_be; obs_wd = dmem_wdata; obs_addr = dmem_addr; obs_we = dmem_we;
        if (waits >= 0 && wcnt == waits) begin
          dmem_ack = 1'b1; dmem_rdata = rd;
        end else begin
          wcnt++;
        end
      end
      #1;
      if (mem_stall) obs_stalls++;
      else begin
`ifdef ALIGN_CHECK_EN
        obs_mis = Mmisalign;
`endif
        obs_done = 1;
        break;
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    if (!keep) begin
      Mvalid = 1'b0; Mmem_op = 4'd0;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (dmem_req !== 1'b0)     begin n_err++; $display("FAIL reset_req got %b want 0", dmem_req); end
    n_cmp++; if (mem_stall !== 1'b0)    begin n_err++; $display("FAIL reset_stall got %b want 0", mem_stall); end
    n_cmp++; if (Mdmem_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata got %h want 0", Mdmem_rdata); end
    n_cmp++; if ({dmem_we, dmem_be, dmem_addr, dmem_wdata, Mbus_err} !== 70'd0)
      begin n_err++; $display("FAIL reset_bus got we=%b be=%h a=%h wd=%h err=%b want 0", dmem_we, dmem_be, dmem_addr, dmem_wdata, Mbus_err); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_lw_zero_wait();
    do_access(4'd5, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0);
    n_cmp++; if (!obs_done)              begin n_err++; $display("FAIL lw_done got 0 want 1"); end
    n_cmp++; if (obs_reqs !== 1)         begin n_err++; $display("FAIL lw_req_cycles got %0d want 1", obs_reqs); end
    n_cmp++; if (obs_stalls !== 2)       begin n_err++; $display("FAIL lw_stall_cycles got %0d want 2", obs_stalls); end
    n_cmp++; if (obs_be !== 4'hF || obs_we !== 1'b0 || obs_addr !== 32'h100)
      begin n_err++; $display("FAIL lw_bus got be=%h we=%b a=%h want be=f we=0 a=100", obs_be, obs_we, obs_addr); end
    n_cmp++; if (Mdmem_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_data got %h want deadbeef", Mdmem_rdata); end
  endtask

  task automatic test_loads();
    logic [3:0]  ops [6] = '{4'd1, 4'd2, 4'd4, 4'd3, 4'd3, 4'd1};
    logic [31:0] adr [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h102, 32'h101};
    logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'h00001234, 32'hFFFF80FF, 32'h00000012};
    logic [3:0]  ebe [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b1100, 4'b0010};
    for (int i = 0; i < 6; i++) begin
      do_access(ops[i], adr[i], 32'h0, 1, 32'h80FF1234, 0);
      n_cmp++; if (Mdmem_rdata !== exp[i]) begin n_err++; $display("FAIL load_data[%0d] got %h want %h", i, Mdmem_rdata, exp[i]); end
      n_cmp++; if (obs_be !== ebe[i] || obs_addr !== 32'h100 || obs_we !== 1'b0)
        begin n_err++; $display("FAIL load_bus[%0d] got be=%b a=%h we=%b want be=%b a=100 we=0", i, obs_be, obs_addr, obs_we, ebe[i]); end
    end
  endtask

  task automatic test_stores();
    logic [31:0] prev;
    prev = Mdmem_rdata;
    do_access(4'd7, 32'h0A6, 32'h1234ABCD, 3, 32'h55555555, 0);
    n_cmp++; if (obs_be !== 4'b1100 || obs_wd !== 32'hABCDABCD || obs_we !== 1'b1 || obs_addr !== 32'h0A4)
      begin n_err++; $display("FAIL sh_bus got be=%b wd=%h we=%b a=%h want 1100 abcdabcd 1 a4", obs_be, obs_wd, obs_we, obs_addr); end
    n_cmp++; if (obs_stalls !== 5 || obs_reqs !== 4)
      begin n_err++; $display("FAIL sh_timing got stall=%0d req=%0d want 5/4", obs_stalls, obs_reqs); end
    n_cmp++; if (Mdmem_rdata !== prev) begin n_err++; $display("FAIL store_keeps_rdata got %h want %h", Mdmem_rdata, prev); end
    do_access(4'd6, 32'h0A5, 32'h1234ABCD, 0, 32'h0, 0);
    n_cmp++; if (obs_be !== 4'b0010 || obs_wd !== 32'hCDCDCDCD || obs_we !== 1'b1)
      begin n_err++; $display("FAIL sb_bus got be=%b wd=%h we=%b want 0010 cdcdcdcd 1", obs_be, obs_wd, obs_we); end
    do_access(4'd8, 32'h0A8, 32'h1234ABCD, 0, 32'h0, 0);
    n_cmp++; if (obs_be !== 4'b1111 || obs_wd !== 32'h1234ABCD || obs_addr !== 32'h0A8)
      begin n_err++; $display("FAIL sw_bus got be=%b wd=%h a=%h want 1111 1234abcd a8", obs_be, obs_wd, obs_addr); end
    n_cmp++; if (Mdmem_rdata !== prev) begin n_err++; $display("FAIL sw_keeps_rdata got %h want %h", Mdmem_rdata, prev); end
  endtask

  task automatic test_no_op();
    // Invalid op codes and Mvalid=0 must not stall or request.
    @(negedge clk); Mvalid = 1'b1; Mmem_op = 4'd12; Malu = 32'h40;
    #1;
    n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL noop_stall got %b want 0", mem_stall); end
    @(negedge clk);
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL noop_req got %b want 0", dmem_req); end
    Mvalid = 1'b0; Mmem_op = 4'd5; #1;
    n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL novalid_stall got %b want 0", mem_stall); end
    Mmem_op = 4'd0;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk); Mvalid = 1'b1; Mmem_op = 4'd5; Malu = 32'h200;
    @(negedge clk);  // first REQ cycle, no ack
    @(negedge clk);  // second REQ cycle
    n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre_req got %b want 1", dmem_req); end
    rst_n = 1'b0; #1;
    n_cmp++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || Mdmem_rdata !== 32'd0)
      begin n_err++; $display("FAIL rst_mid_outputs got req=%b stall=%b rd=%h want 0 0 0", dmem_req, mem_stall, Mdmem_rdata); end
    Mvalid = 1'b0; Mmem_op = 4'd0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0)
      begin n_err++; $display("FAIL rst_mid_idle got req=%b stall=%b want 0 0", dmem_req, mem_stall); end
  endtask

  task automatic test_timeout();
    do_access(4'd5, 32'h300, 32'h0, 0, 32'h11111111, 0);  // prime Mdmem_rdata
    do_access(4'd5, 32'h304, 32'h0, -1, 32'h0, 0);
    n_cmp++; if (!obs_done || obs_reqs !== 4 || obs_stalls !== 5)
      begin n_err++; $display("FAIL timeout_timing got done=%0d req=%0d stall=%0d want 1/4/5", obs_done, obs_reqs, obs_stalls); end
    n_cmp++; if (Mbus_err !== 1'b1) begin n_err++; $display("FAIL timeout_err got %b want 1", Mbus_err); end
    n_cmp++; if (Mdmem_rdata !== 32'd0) begin n_err++; $display("FAIL timeout_rdata got %h want 0", Mdmem_rdata); end
    do_access(4'd8, 32'h308, 32'h77, 0, 32'h0, 0);
    n_cmp++; if (Mbus_err !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", Mbus_err); end
  endtask

  task automatic test_back_to_back();
    do_access(4'd5, 32'h400, 32'h0, 0, 32'hCAFEF00D, 1);
    // Still in DONE: present the next instruction immediately.
    Mmem_op = 4'd2; Malu = 32'h501;
    @(negedge clk); #1;  // IDLE cycle
    n_cmp++; if (dmem_req !== 1'b0 || mem_stall !== 1'b1)
      begin n_err++; $display("FAIL b2b_idle got req=%b stall=%b want 0 1", dmem_req, mem_stall); end
    n_cmp++; if (Mdmem_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_first got %h want cafef00d", Mdmem_rdata); end
    @(negedge clk);  // REQ cycle
    n_cmp++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h500 || dmem_be !== 4'b0010)
      begin n_err++; $display("FAIL b2b_req got req=%b a=%h be=%b want 1 500 0010", dmem_req, dmem_addr, dmem_be); end
    dmem_ack = 1'b1; dmem_rdata = 32'h0000A500;
    @(negedge clk); dmem_ack = 1'b0; #1;  // DONE
    n_cmp++; if (mem_stall !== 1'b0 || Mdmem_rdata !== 32'h000000A5)
      begin n_err++; $display("FAIL b2b_second got stall=%b rd=%h want 0 000000a5", mem_stall, Mdmem_rdata); end
    Mvalid = 1'b0; Mmem_op = 4'd0;
  endtask

  task automatic test_align();
`ifdef ALIGN_CHECK_EN
    logic [31:0] prev;
    prev = Mdmem_rdata;
    do_access(4'd5, 32'h102, 32'h0, 0, 32'h99999999, 0);
    n_cmp++; if (obs_reqs !== 0 || obs_stalls !== 1 || obs_mis !== 1'b1)
      begin n_err++; $display("FAIL misalign_lw got req=%0d stall=%0d mis=%b want 0/1/1", obs_reqs, obs_stalls, obs_mis); end
    n_cmp++; if (Mdmem_rdata !== prev || Mbus_err !== 1'b0)
      begin n_err++; $display("FAIL misalign_keep got rd=%h err=%b want %h 0", Mdmem_rdata, Mbus_err, prev); end
    @(negedge clk);
    n_cmp++; if (Mmisalign !== 1'b0) begin n_err++; $display("FAIL misalign_pulse got %b want 0", Mmisalign); end
    do_access(4'd7, 32'h0A1, 32'h0, 0, 32'h0, 0);
    n_cmp++; if (obs_reqs !== 0 || obs_mis !== 1'b1)
      begin n_err++; $display("FAIL misalign_sh got req=%0d mis=%b want 0/1", obs_reqs, obs_mis); end
`else
    // Low bits beyond the access width are ignored.
    do_access(4'd5, 32'h102, 32'h0, 0, 32'h99887766, 0);
    n_cmp++; if (obs_reqs !== 1 || obs_addr !== 32'h100 || Mdmem_rdata !== 32'h99887766)
      begin n_err++; $display("FAIL lw_lowbits got req=%0d a=%h rd=%h want 1 100 99887766", obs_reqs, obs_addr, Mdmem_rdata); end
    do_access(4'd3, 32'h103, 32'h0, 0, 32'h80FF1234, 0);
    n_cmp++; if (Mdmem_rdata !== 32'hFFFF80FF || obs_be !== 4'b1100)
      begin n_err++; $display("FAIL lh_lowbit got rd=%h be=%b want ffff80ff 1100", Mdmem_rdata, obs_be); end
`endif
  endtask

  initial begin
    test_reset();
    test_lw_zero_wait();
    test_loads();
    test_stores();
    test_no_op();
    test_reset_mid_access();
    test_timeout();
    test_back_to_back();
    test_align();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
